// File: rtl/cvt_req_packer.sv
// rtl/cvt_req_packer.sv - conversion request packer: header + payload words into a 48-bit FIFO
//
// Purpose:
//   Accepts one float/fixed conversion request per valid/ready handshake and
//   writes it into the conversion engine's input FIFO as one header word
//   followed by NW payload words (NW = 1 for 32-bit, 2 for 64/80-bit operands).
//   Writes are issued only while the FIFO is not full.
//
// Optional feature macro: CVT_PACK_CHECKSUM_EN
//   When defined, a trailer word holding the XOR of all payload words follows
//   the payload, and done follows the trailer write.
//
// Ports:
//   clk        clock
//   rstn       synchronous reset, active HIGH (1 = reset)
//   req_valid  request present
//   req_ready  packer can accept a request (IDLE and not in reset)
//   req_app    direction: 0 float->fixed, 1 fixed->float, 2/3 illegal
//   req_size   operand size: 1 = 32b, 2 = 64b, 3 = 80b, others illegal
//   req_data   operand, LSB-aligned
//   full       downstream FIFO full
//   dataout    FIFO write data (0 while idle)
//   wren       FIFO write strobe
//   busy       request in flight
//   done       one-cycle pulse after the final word of a request is written
//   err        one-cycle pulse after an illegal request is accepted

module cvt_req_packer #(
  parameter int DATAOUT = 48,
  parameter int SEQ_W   = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_app,
  input  logic [2:0]         req_size,
  input  logic [79:0]        req_data,
  input  logic               full,
  output logic [DATAOUT-1:0] dataout,
  output logic               wren,
  output logic               busy,
  output logic               done,
  output logic               err
);

`ifdef CVT_PACK_CHECKSUM_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2,
    ST_CSUM = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PAY  = 2'd2
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [1:0]         app_q, app_d;
  logic [2:0]         size_q, size_d;
  logic [2:0]         nw_q, nw_d;
  logic [95:0]        buf_q, buf_d;
  logic               k_q, k_d;
  logic [SEQ_W-1:0]   seq_q, seq_d;
  logic [7:0]         tag_q, tag_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
`ifdef CVT_PACK_CHECKSUM_EN
  logic [47:0]        csum_q, csum_d;
`endif

  logic               ready_c;
  logic               accept_c;
  logic               legal_c;
  logic               wr_c;
  logic               last_word_c;
  logic [47:0]        word_c;
  logic [47:0]        pay_word_c;
  logic [95:0]        buf_load_c;
  logic [2:0]         nw_load_c;

  // Request decode; only meaningful while accepting.
  always_comb begin
    legal_c = ~req_app[1] &&
              ((req_size == 3'd1) || (req_size == 3'd2) || (req_size == 3'd3));
    nw_load_c = (req_size == 3'd1) ? 3'd1 : 3'd2;
    case (req_size)
      3'd1:    buf_load_c = {req_data[31:0], 64'b0};
      3'd2:    buf_load_c = {req_data[63:0], 32'b0};
      default: buf_load_c = {req_data[79:0], 16'b0};
    endcase
  end

  // NW is at most 2, so the current payload word is the last one either when
  // NW is 1 or when the index has already reached 1.
  assign last_word_c = (nw_q == 3'd1) || k_q;
  assign pay_word_c  = k_q ? buf_q[47:0] : buf_q[95:48];

  // Handshake is masked during reset so nothing is latched while rstn is high.
  assign ready_c  = (state_q == ST_IDLE) && !rstn;
  assign accept_c = req_valid && ready_c;

  always_comb begin
    state_d = state_q;
    app_d   = app_q;
    size_d  = size_q;
    nw_d    = nw_q;
    buf_d   = buf_q;
    k_d     = k_q;
    seq_d   = seq_q;
    tag_d   = tag_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr_c    = 1'b0;
    word_c  = 48'b0;
`ifdef CVT_PACK_CHECKSUM_EN
    csum_d  = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (legal_c) begin
            app_d   = req_app;
            size_d  = req_size;
            nw_d    = nw_load_c;
            buf_d   = buf_load_c;
            k_d     = 1'b0;
            // Header carries the tag value before this request's increment.
            tag_d   = 8'(seq_q);
            seq_d   = seq_q + 1'b1;
            state_d = ST_HDR;
`ifdef CVT_PACK_CHECKSUM_EN
            csum_d  = 48'b0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end

      ST_HDR: begin
        word_c = {app_q, size_q, nw_q, tag_q, 32'b0};
        wr_c   = !full;
        if (wr_c) begin
          k_d     = 1'b0;
          state_d = ST_PAY;
        end
      end

      ST_PAY: begin
        word_c = pay_word_c;
        wr_c   = !full;
        if (wr_c) begin
`ifdef CVT_PACK_CHECKSUM_EN
          csum_d = csum_q ^ pay_word_c;
`endif
          if (last_word_c) begin
            k_d = 1'b0;
`ifdef CVT_PACK_CHECKSUM_EN
            state_d = ST_CSUM;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            k_d = 1'b1;
          end
        end
      end

`ifdef CVT_PACK_CHECKSUM_EN
      ST_CSUM: begin
        word_c = csum_q;
        wr_c   = !full;
        if (wr_c) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q <= ST_IDLE;
      app_q   <= 2'b0;
      size_q  <= 3'b0;
      nw_q    <= 3'b0;
      buf_q   <= 96'b0;
      k_q     <= 1'b0;
      seq_q   <= '0;
      tag_q   <= 8'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CVT_PACK_CHECKSUM_EN
      csum_q  <= 48'b0;
`endif
    end else begin
      state_q <= state_d;
      app_q   <= app_d;
      size_q  <= size_d;
      nw_q    <= nw_d;
      buf_q   <= buf_d;
      k_q     <= k_d;
      seq_q   <= seq_d;
      tag_q   <= tag_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CVT_PACK_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // All FIFO-facing outputs are forced quiet while reset is asserted so an
  // aborted request cannot leak a word in the reset cycle itself.
  assign req_ready = ready_c;
  assign wren      = wr_c && !rstn;
  assign dataout   = rstn ? '0 : word_c;
  assign busy      = (state_q != ST_IDLE) && !rstn;
  assign done      = done_q;
  assign err       = err_q;

endmodule
